// File: rtl/pwm_mode_decoder.sv
// RC switch-channel PWM decoder: measures pulse width, debounces the decoded switch position
// and flags signal loss. Define PWM_DECODER_HYST_EN to add a hysteresis band around THRESH_US.
module pwm_mode_decoder #(
  parameter int CLK_PER_US = 50,
  parameter int MIN_US     = 800,
  parameter int MAX_US     = 2200,
  parameter int THRESH_US  = 1500,
  parameter int HYST_US    = 50,
  parameter int CONFIRM    = 3,
  parameter int TIMEOUT_US = 25000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        PWM_IN,
  output logic        MODE_REQ,
  output logic [11:0] PULSE_US,
  output logic        PULSE_VALID,
  output logic        SIGNAL_LOST
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int CW = $clog2(CONFIRM + 1);
  localparam logic [11:0] MIN_W  = 12'(MIN_US);
  localparam logic [11:0] MAX_W  = 12'(MAX_US);
  localparam logic [11:0] TH_W   = 12'(THRESH_US);
  localparam logic [11:0] HI_W   = 12'(THRESH_US + HYST_US);
  localparam logic [11:0] LO_W   = 12'(THRESH_US - HYST_US);
  localparam logic [14:0] TO_W   = 15'(TIMEOUT_US);
`ifdef PWM_DECODER_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  typedef enum logic [1:0] {WAIT_RISE, HIGH, STUCK} state_t;

  logic          sync1_q, sync2_q, level_q, rise_q, fall_q, armed_q;
  logic [1:0]    settle_q;
  logic [PW-1:0] presc_q, presc_d, presc_base;
  logic [11:0]   width_q, width_d, width_base;
  logic [14:0]   frame_q, frame_d, frame_base;
  logic          wrap, timeout, to_fired_q, to_fired_d;
  state_t        state_q, state_d;
  logic          mode_q, mode_d, lost_q, lost_d, cand_q, cand_d, valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   pulse_q, pulse_d;
  logic          in_range, hyst_bit, plain_bit, dbit;

  // Edges are only trusted once the synchronizer holds real samples and the line was seen low,
  // so a pulse already in progress at reset release never produces a rising edge.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      sync1_q <= PWM_IN;
      sync2_q <= sync1_q;
      level_q <= sync2_q;
      rise_q  <= armed_q & sync2_q & ~level_q;
      fall_q  <= armed_q & ~sync2_q & level_q;
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end else if (!sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    presc_base = rise_q ? '0 : presc_q;
    width_base = rise_q ? '0 : width_q;
    frame_base = rise_q ? '0 : frame_q;
    wrap       = (presc_base == PW'(CLK_PER_US - 1));
    presc_d    = wrap ? '0 : presc_base + PW'(1);
    width_d    = (wrap && width_base != 12'hFFF) ? width_base + 12'd1 : width_base;
    frame_d    = (wrap && frame_base != 15'h7FFF) ? frame_base + 15'd1 : frame_base;
    // Timeout fires once per silent stretch; the next rising edge re-arms it.
    timeout    = (frame_q >= TO_W) && !to_fired_q;
    to_fired_d = rise_q ? 1'b0 : (to_fired_q | timeout);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lost_d    = lost_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    pulse_d   = pulse_q;
    valid_d   = 1'b0;
    in_range  = (width_q >= MIN_W) && (width_q <= MAX_W);
    plain_bit = (width_q >= TH_W);
    hyst_bit  = (width_q >= HI_W) ? 1'b1 : ((width_q < LO_W) ? 1'b0 : mode_q);
    dbit      = HYST_ON ? hyst_bit : plain_bit;

    if (timeout) begin
      lost_d  = 1'b1;
      mode_d  = 1'b0;
      cnt_d   = '0;
      cand_d  = 1'b0;
      state_d = level_q ? STUCK : WAIT_RISE;
    end else begin
      unique case (state_q)
        WAIT_RISE: if (rise_q) state_d = HIGH;
        HIGH: begin
          if (fall_q) begin
            state_d = WAIT_RISE;
            if (in_range) begin
              valid_d = 1'b1;
              pulse_d = width_q;
              if (dbit == cand_q) begin
                if (cnt_q != CW'(CONFIRM)) cnt_d = cnt_q + CW'(1);
              end else begin
                cand_d = dbit;
                cnt_d  = CW'(1);
              end
              if (cnt_d == CW'(CONFIRM)) begin
                mode_d = cand_d;
                lost_d = 1'b0;
              end
            end else begin
              cnt_d = '0;
            end
          end else if (width_q > MAX_W) begin
            state_d = STUCK;
          end
        end
        STUCK: begin
          if (fall_q) begin
            state_d = WAIT_RISE;
            cnt_d   = '0;
          end
        end
        default: state_d = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      presc_q    <= '0;
      width_q    <= '0;
      frame_q    <= '0;
      to_fired_q <= 1'b0;
      state_q    <= WAIT_RISE;
      mode_q     <= 1'b0;
      lost_q     <= 1'b1;
      cand_q     <= 1'b0;
      cnt_q      <= '0;
      pulse_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      width_q    <= width_d;
      frame_q    <= frame_d;
      to_fired_q <= to_fired_d;
      state_q    <= state_d;
      mode_q     <= mode_d;
      lost_q     <= lost_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      valid_q    <= valid_d;
    end
  end

  assign MODE_REQ    = mode_q;
  assign PULSE_US    = pulse_q;
  assign PULSE_VALID = valid_q;
  assign SIGNAL_LOST = lost_q;

endmodule

// File: tb/tb_pwm_mode_decoder.sv
// Self-checking bench for pwm_mode_decoder with time-scaled parameters (1 us = 2 clocks).
`timescale 1ns/1ps
module tb_pwm_mode_decoder;
  localparam int C     = 2;
  localparam int MIN   = 80;
  localparam int MAX   = 220;
  localparam int TH    = 150;
  localparam int HY    = 5;
  localparam int CF    = 3;
  localparam int TO    = 2500;
  localparam int US_NS = C * 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm;
  logic        mode;
  logic [11:0] pus;
  logic        pv;
  logic        lost;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_rise_cyc = 0;

  // Reference state: decoded history since the last invalidation, plus expected outputs.
  bit m_mode;
  bit m_lost;
  int m_pulse;
  bit hist[$];

  pwm_mode_decoder #(
    .CLK_PER_US(C), .MIN_US(MIN), .MAX_US(MAX), .THRESH_US(TH),
    .HYST_US(HY), .CONFIRM(CF), .TIMEOUT_US(TO)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .PWM_IN(pwm),
    .MODE_REQ(mode), .PULSE_US(pus), .PULSE_VALID(pv), .SIGNAL_LOST(lost)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_pulse(input int w, output bit ev);
    bit b;
    bit same;
    ev = (w >= MIN) && (w <= MAX);
    if (!ev) begin
      hist.delete();
      return;
    end
    m_pulse = w;
`ifdef PWM_DECODER_HYST_EN
    if (w >= TH + HY) b = 1'b1;
    else if (w < TH - HY) b = 1'b0;
    else b = m_mode;
`else
    b = (w >= TH);
`endif
    hist.push_back(b);
    if (hist.size() > CF) void'(hist.pop_front());
    if (hist.size() == CF) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != b) same = 1'b0;
      if (same) begin
        m_mode = b;
        m_lost = 1'b0;
      end
    end
  endtask

  task automatic send_pulse(input int w, input int low_us, input string tag);
    bit          ev;
    int          seen;
    int          extra;
    logic [11:0] c_pus;
    logic        c_mode;
    logic        c_lost;
    model_pulse(w, ev);
    @(posedge clk);
    #7 pwm = 1'b1;
    last_rise_cyc = cyc;
    #(w * US_NS) pwm = 1'b0;
    seen = 0;
    extra = 0;
    c_pus = pus;
    c_mode = mode;
    c_lost = lost;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (pv) begin
        if (seen == 0) begin
          seen = i;
          c_pus = pus;
          c_mode = mode;
          c_lost = lost;
        end else begin
          extra++;
        end
      end
    end
    if (!ev) begin
      c_pus = pus;
      c_mode = mode;
      c_lost = lost;
    end
    n_checks++;
    if (seen !== (ev ? 5 : 0)) $display("FAIL %s_strobe w=%0d: strobe at negedge %0d, required %0d", tag, w, seen, ev ? 5 : 0);
    else n_pass++;
    n_checks++;
    if (extra !== 0) $display("FAIL %s_strobe_len w=%0d: %0d extra strobe cycles, required 0", tag, w, extra);
    else n_pass++;
    n_checks++;
    if (c_pus !== 12'(m_pulse)) $display("FAIL %s_pulse_us w=%0d: got %0d, required %0d", tag, w, c_pus, m_pulse);
    else n_pass++;
    n_checks++;
    if (c_mode !== m_mode) $display("FAIL %s_mode w=%0d: got %0b, required %0b", tag, w, c_mode, m_mode);
    else n_pass++;
    n_checks++;
    if (c_lost !== m_lost) $display("FAIL %s_lost w=%0d: got %0b, required %0b", tag, w, c_lost, m_lost);
    else n_pass++;
    $display("%s: w=%0d valid=%0b pulse_us=%0d mode=%0b lost=%0b", tag, w, (seen != 0), c_pus, c_mode, c_lost);
    repeat (low_us * C - 8) @(negedge clk);
  endtask

  task automatic wait_timeout(input string tag);
    int waited;
    int el;
    waited = 0;
    while (lost !== 1'b1 && waited < (TO + 50) * C) begin
      @(negedge clk);
      waited++;
    end
    el = cyc - last_rise_cyc;
    m_mode = 1'b0;
    m_lost = 1'b1;
    hist.delete();
    n_checks++;
    if (lost !== 1'b1) $display("FAIL %s_lost: got %0b after %0d cycles, required 1", tag, lost, waited);
    else n_pass++;
    n_checks++;
    if (el < TO * C - C || el > TO * C + C + 8) $display("FAIL %s_time: lost after %0d cycles, required %0d..%0d", tag, el, TO * C - C, TO * C + C + 8);
    else n_pass++;
    n_checks++;
    if (mode !== m_mode) $display("FAIL %s_mode: got %0b, required 0", tag, mode);
    else n_pass++;
    n_checks++;
    if (pus !== 12'(m_pulse)) $display("FAIL %s_pulse_us: got %0d, required %0d", tag, pus, m_pulse);
    else n_pass++;
    $display("%s: lost=%0b after %0d cycles, mode=%0b", tag, lost, el, mode);
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mode !== 1'b0) $display("FAIL reset_mode: got %0b, required 0", mode); else n_pass++;
    n_checks++;
    if (pus !== 12'd0) $display("FAIL reset_pulse_us: got %0d, required 0", pus); else n_pass++;
    n_checks++;
    if (pv !== 1'b0) $display("FAIL reset_valid: got %0b, required 0", pv); else n_pass++;
    n_checks++;
    if (lost !== 1'b1) $display("FAIL reset_lost: got %0b, required 1", lost); else n_pass++;
    @(posedge clk);
    #7 rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (pv !== 1'b0 || lost !== 1'b1) $display("FAIL reset_idle: valid=%0b lost=%0b, required 0/1", pv, lost); else n_pass++;
    $display("reset: mode=%0b pulse_us=%0d valid=%0b lost=%0b", mode, pus, pv, lost);
  endtask

  task automatic test_confirm();
    for (int i = 0; i < 3; i++) send_pulse(190, 60, "confirm");
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 3; i++) begin
      send_pulse(110, 60, "alternate");
      send_pulse(190, 60, "alternate");
    end
    for (int i = 0; i < 3; i++) send_pulse(110, 60, "release");
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 3; i++) send_pulse(152, 60, "hysteresis");
  endtask

  task automatic test_invalid();
    send_pulse(110, 60, "invalid");
    send_pulse(110, 60, "invalid");
    send_pulse(110, 60, "invalid");
    send_pulse(190, 60, "invalid");
    send_pulse(190, 60, "invalid");
    send_pulse(250, 60, "invalid");
    send_pulse(190, 60, "invalid");
    send_pulse(50, 60, "invalid");
    send_pulse(190, 60, "invalid");
    send_pulse(190, 60, "invalid");
    send_pulse(190, 60, "invalid");
  endtask

  task automatic test_boundaries();
    send_pulse(MIN, 60, "boundary");
    send_pulse(MIN - 1, 60, "boundary");
    send_pulse(MAX, 60, "boundary");
    send_pulse(MAX + 1, 60, "boundary");
    for (int i = 0; i < 3; i++) send_pulse(TH - 1, 60, "boundary");
    for (int i = 0; i < 3; i++) send_pulse(TH, 60, "boundary");
  endtask

  task automatic test_random();
    int k;
    int w;
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) w = $urandom_range(20, MIN - 1);
      else if (k == 1) w = $urandom_range(MAX + 1, MAX + 40);
      else w = $urandom_range(MIN, MAX);
      send_pulse(w, $urandom_range(30, 120), "random");
    end
  endtask

  task automatic test_timeout_low();
    send_pulse(190, 60, "timeout_low");
    send_pulse(190, 60, "timeout_low");
    send_pulse(190, 10, "timeout_low");
    wait_timeout("timeout_low");
  endtask

  task automatic test_timeout_high();
    int seen;
    for (int i = 0; i < 3; i++) send_pulse(190, 60, "timeout_high");
    @(posedge clk);
    #7 pwm = 1'b1;
    last_rise_cyc = cyc;
    wait_timeout("timeout_high");
    @(posedge clk);
    #7 pwm = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pv) seen++;
    end
    n_checks++;
    if (seen !== 0 || mode !== 1'b0 || lost !== 1'b1) $display("FAIL stuck_release: strobes=%0d mode=%0b lost=%0b, required 0/0/1", seen, mode, lost);
    else n_pass++;
    $display("stuck_release: strobes=%0d mode=%0b lost=%0b", seen, mode, lost);
    repeat (60 * C) @(negedge clk);
    for (int i = 0; i < 3; i++) send_pulse(110, 60, "recover");
  endtask

  task automatic test_reset_midpulse();
    int seen;
    @(posedge clk);
    #7 pwm = 1'b1;
    #(50 * US_NS) rst = 1'b1;
    repeat (10) @(posedge clk);
    #7 rst = 1'b0;
    #(140 * US_NS) pwm = 1'b0;
    m_mode = 1'b0;
    m_lost = 1'b1;
    m_pulse = 0;
    hist.delete();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pv) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL midreset_strobe: got %0d strobes, required 0", seen); else n_pass++;
    n_checks++;
    if (mode !== 1'b0 || lost !== 1'b1 || pus !== 12'd0) $display("FAIL midreset_state: mode=%0b lost=%0b pulse_us=%0d, required 0/1/0", mode, lost, pus);
    else n_pass++;
    $display("midreset: strobes=%0d mode=%0b lost=%0b pulse_us=%0d", seen, mode, lost, pus);
    repeat (60 * C) @(negedge clk);
    send_pulse(190, 60, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    pwm = 1'b0;
    m_mode = 1'b0;
    m_lost = 1'b1;
    m_pulse = 0;
    test_reset();
    test_confirm();
    test_alternate();
    test_hysteresis();
    test_invalid();
    test_boundaries();
    test_random();
    test_timeout_low();
    test_timeout_high();
    test_reset_midpulse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
